pc_gen: RTL

Parametrised fetch-PC generator that replaces the flat PC register plus next-address adder with a single unit. It owns the fetch PC, selects the next PC with fixed priority (trap, execute-stage misprediction redirect, return-address-stack prediction, sequential), and validates each resolved control transfer against the PC the front end actually followed. It sits between the trap logic, the EX stage and the instruction fetch port.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_gen_ras.sv | 70 +++++++
 rtl/pc_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants and helpers for the fetch-PC generator.
//   STEP_RVC / STEP_STD : byte step for compressed / standard instructions
//   RESET_VEC           : default PC loaded at reset
//   ras_cnt_w()         : width of the RAS occupancy counter for a given depth
package pc_pkg;

    localparam int unsigned STEP_RVC  = 2;
    localparam int unsigned STEP_STD  = 4;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;

    // Counter must hold the value RAS_DEPTH itself, hence one extra bit.
    function automatic int unsigned ras_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack.
//   clock, reset_n : clock and asynchronous active-low reset
//   push, pop      : push push_data / pop the top entry (both: replace top)
//   push_data      : return address to push
//   top            : current top-of-stack entry
//   count          : number of valid entries (saturates at RAS_DEPTH)
module pc_gen_ras
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4,
    localparam int unsigned PW       = $clog2(RAS_DEPTH),
    localparam int unsigned CW       = ras_cnt_w(RAS_DEPTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic [CW-1:0]   count
);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [XLEN-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, ptr_m1;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_pop;

    // ptr_q points at the next free slot; the top lives one below it.
    assign ptr_m1 = ptr_q - 1'b1;
    assign do_pop = pop && (cnt_q != '0);
    assign top    = mem_q[ptr_m1];
    assign count  = cnt_q;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push && do_pop) begin
            mem_d[ptr_m1] = push_data;
        end else if (push) begin
            // When full, ptr_q already sits on the oldest entry, so this
            // write is the circular overwrite.
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + 1'b1;
            if (cnt_q != CW'(RAS_DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (do_pop) begin
            ptr_d = ptr_m1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: owns the fetch PC, picks the next PC by priority
// (trap, EX redirect, pause, RAS prediction, sequential) and checks each
// resolved EX control transfer against the PC fetch actually followed.
//   clock, reset_n          : clock and asynchronous active-low reset
//   pause                   : fetch stall, holds pc unless redirected
//   trap_valid, trap_vec    : trap redirect request and target
//   ex_valid, s_*, alu_zero : EX-stage control bits and ALU flag
//   ex_pc, imm, alu_o       : EX PC, immediate, ALU result (jump target)
//   ex_pred_npc             : PC fetch chose after ex_pc
//   if_call, if_ret, if_rvc : predecode of the fetched instruction
//   pc, npc                 : registered fetch PC, combinational next PC
//   branch_take, redirect   : EX branch taken, EX misprediction flush
//   misalign                : resolved target misaligned (RVC_EN=0)
//   ras_count               : valid RAS entries
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET     = XLEN'(RESET_VEC),
    parameter bit                RVC_EN    = 1'b1,
    parameter int unsigned       RAS_DEPTH = 4,
    localparam int unsigned      CW        = ras_cnt_w(RAS_DEPTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            pause,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            ex_valid,
    input  logic            s_jump,
    input  logic            s_jalr,
    input  logic            s_branch,
    input  logic            s_branch_zero,
    input  logic            alu_zero,
    input  logic            s_rvc,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_o,
    input  logic [XLEN-1:0] ex_pred_npc,
    input  logic            if_call,
    input  logic            if_ret,
    input  logic            if_rvc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic            branch_take,
    output logic            redirect,
    output logic            misalign,
    output logic [CW-1:0]   ras_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] step, ex_step, pc_seq, act, ras_top;
    logic            fetch_path, ras_hit;

    // JAL and JALR both take their target from alu_o; the distinction
    // only matters to predecode, not here.
    logic unused_s_jalr;
    assign unused_s_jalr = s_jalr;

    assign step    = (RVC_EN && if_rvc) ? XLEN'(STEP_RVC) : XLEN'(STEP_STD);
    assign ex_step = (RVC_EN && s_rvc)  ? XLEN'(STEP_RVC) : XLEN'(STEP_STD);
    assign pc_seq  = pc_q + step;

    assign branch_take = ex_valid & s_branch & ~(s_branch_zero ^ alu_zero);

    always_comb begin
        act = ex_pc + ex_step;
        if (s_jump) begin
            act = {alu_o[XLEN-1:1], 1'b0};
        end else if (branch_take) begin
            act = ex_pc + imm;
        end
    end

    assign misalign = ex_valid & ~RVC_EN & (s_jump | branch_take) & act[1];
    assign redirect = ex_valid & ~misalign & (act != ex_pred_npc);

    // The RAS only advances when the fetch-side prediction is what gets used.
    assign fetch_path = ~trap_valid & ~redirect & ~pause;
    assign ras_hit    = if_ret & (ras_count != '0);

    always_comb begin
        npc = pc_seq;
        if (trap_valid) begin
            npc = trap_vec;
        end else if (redirect) begin
            npc = act;
        end else if (pause) begin
            npc = pc_q;
        end else if (ras_hit) begin
            npc = ras_top;
        end
    end

    assign pc_d = npc;
    assign pc   = pc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    pc_gen_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fetch_path & if_call),
        .pop       (fetch_path & if_ret),
        .push_data (pc_seq),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule
